writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have port `clk`, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports `Whi` and `Wlo`, input, 16 bits each: hi/lo register values from the Memory/Writeback register.
REQ-005 SHALL have port `Walu`, input, 16 bits: ALU result.
REQ-006 SHALL have port `Wdmout`, input, 16 bits: data-memory read data.
REQ-007 SHALL have port `Wmodout`, input, 16 bits: modulo unit result.
REQ-008 SHALL have port `Wmod`, input, 1 bit: select `Wmodout`, overriding `Wregdata`.
REQ-009 SHALL have port `Wregdata`, input, 2 bits: write-data select (00 `Walu`, 01 `Wdmout`, 10 `Whi`, 11 `Wlo`).
REQ-010 SHALL have port `Wwriteadd`, input, 4 bits: destination register index.
REQ-011 SHALL have port `Wwe3`, input, 1 bit: register-file write enable.
REQ-012 SHALL have ports `Dra1` and `Dra2`, input, 4 bits each: decode-stage read addresses.
REQ-013 SHALL have ports `Drd1` and `Drd2`, output, 16 bits each: read data for `Dra1` and `Dra2`.
REQ-014 SHALL have port `Wresult`, output, 16 bits: selected writeback value, used for hazard forwarding.
REQ-015 SHALL have port `wb_count`, output, 16 bits: count of committed register writes.
REQ-016 SHALL have port `last_wadd`, output, 4 bits: index of the most recently committed register write.

Function
REQ-017 `Wresult` SHALL be combinational: `Wmodout` if `Wmod`=1, otherwise the value chosen by `Wregdata` per REQ-009.
REQ-018 Storage SHALL be 16 registers x 16 bits, R0..R15.
REQ-019 A write is committed when `Wwe3`=1 and `Wwriteadd`!=0. It SHALL write `Wresult` into R[`Wwriteadd`] on the rising edge (1-cycle latency).
REQ-020 R0 SHALL always read 0x0000, and writes with `Wwriteadd`=0 SHALL be dropped and not counted.
REQ-021 `Drd1` and `Drd2` SHALL be combinational reads of R[`Dra1`] and R[`Dra2`]; both ports are independent and may share an address.
REQ-022 On every committed write, `wb_count` SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-023 On every committed write, `last_wadd` SHALL load `Wwriteadd`.
REQ-024 When `Wwe3`=0, all state SHALL hold; input changes SHALL affect only `Wresult` and not storage.
REQ-025 A write and a read of the same register in the same cycle SHALL be governed by REQ-031/REQ-032.

Reset
REQ-026 When `rst_n`=0, all R1..R15 SHALL be set to 0x0000 immediately, without waiting for a clock edge.
REQ-027 When `rst_n`=0, `wb_count` SHALL be 0x0000 and `last_wadd` SHALL be 0x0 immediately.
REQ-028 While `rst_n`=0, writes SHALL be ignored.
REQ-029 A reset asserted in the same cycle as a write SHALL win, leaving the target register at 0x0000.
REQ-030 After `rst_n` deasserts, the first rising edge SHALL perform normal writes.

Configuration
REQ-031 With macro `WB_BYPASS_EN` defined, a read port whose address equals a committed write's `Wwriteadd` in the same cycle SHALL return `Wresult` (write-through). R0 SHALL still read 0x0000.
REQ-032 Without `WB_BYPASS_EN`, such a read SHALL return the old stored value, and the new value SHALL be visible from the next cycle.

Verification
REQ-033 Reset check: assert `rst_n`=0 mid-run after writing R5=0x1234, then read R5 -> `Drd1`=0x0000, `wb_count`=0, `last_wadd`=0.
REQ-034 Select mux: with `Walu`=0x0011, `Wdmout`=0x0022, `Whi`=0x0033, `Wlo`=0x0044, `Wmodout`=0x0055, sweep `Wregdata` 0..3 with `Wmod`=0, then set `Wmod`=1 -> `Wresult`=0x0011/0x0022/0x0033/0x0044, then 0x0055.
REQ-035 R0 guard: `Wwe3`=1, `Wwriteadd`=0, `Walu`=0xFFFF -> `Drd1`(`Dra1`=0)=0x0000 and `wb_count` unchanged.
REQ-036 Bypass: write R7=0xBEEF with `Dra2`=7 in the same cycle -> `Drd2`=0xBEEF in that cycle when `WB_BYPASS_EN` is defined, the old value 0x0000 when it is not, and 0xBEEF on the next cycle in both builds.
REQ-037 Counter wrap: preload via 65535 writes so `wb_count`=0xFFFF, then one more write to R3 -> `wb_count`=0x0000 and `last_wadd`=3.
REQ-038 Hold: `Wwe3`=0 for 10 cycles with random data inputs -> all registers, `wb_count` and `last_wadd` unchanged.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus: result selects, register-file write port, two decode read ports and
// the commit-tracking outputs.
interface writeback_regfile_if;
    logic [15:0] Whi;
    logic [15:0] Wlo;
    logic [15:0] Walu;
    logic [15:0] Wdmout;
    logic [15:0] Wmodout;
    logic        Wmod;
    logic [1:0]  Wregdata;
    logic [3:0]  Wwriteadd;
    logic        Wwe3;
    logic [3:0]  Dra1;
    logic [3:0]  Dra2;
    logic [15:0] Drd1;
    logic [15:0] Drd2;
    logic [15:0] Wresult;
    logic [15:0] wb_count;
    logic [3:0]  last_wadd;

    modport master (
        output Whi, Wlo, Walu, Wdmout, Wmodout, Wmod, Wregdata, Wwriteadd, Wwe3, Dra1, Dra2,
        input  Drd1, Drd2, Wresult, wb_count, last_wadd
    );

    modport slave (
        input  Whi, Wlo, Walu, Wdmout, Wmodout, Wmod, Wregdata, Wwriteadd, Wwe3, Dra1, Dra2,
        output Drd1, Drd2, Wresult, wb_count, last_wadd
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback result select plus a 16x16 register file with R0 hardwired to zero.
// Define WB_BYPASS_EN to forward a same-cycle committed write to the read ports.
module writeback_regfile (
    input  logic                   clk,
    input  logic                   rst_n,
    writeback_regfile_if.slave     wb
);

    logic [15:0] regs_q [16];
    logic [15:0] wb_count_q;
    logic [3:0]  last_wadd_q;
    logic [15:0] wresult;
    logic        commit;

    always_comb begin
        wresult = wb.Walu;
        if (wb.Wmod) begin
            wresult = wb.Wmodout;
        end else begin
            unique case (wb.Wregdata)
                2'b00:   wresult = wb.Walu;
                2'b01:   wresult = wb.Wdmout;
                2'b10:   wresult = wb.Whi;
                default: wresult = wb.Wlo;
            endcase
        end
    end

    // Writes to R0 are dropped entirely, including from the commit counter.
    assign commit = wb.Wwe3 && (wb.Wwriteadd != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (commit) begin
            regs_q[wb.Wwriteadd] <= wresult;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q  <= 16'h0000;
            last_wadd_q <= 4'h0;
        end else if (commit) begin
            wb_count_q  <= wb_count_q + 16'd1;
            last_wadd_q <= wb.Wwriteadd;
        end
    end

    function automatic logic [15:0] read_port(input logic [3:0] addr);
        logic [15:0] data;
        data = 16'h0000;
        if (addr != 4'd0) begin
            data = regs_q[addr];
`ifdef WB_BYPASS_EN
            if (commit && (addr == wb.Wwriteadd)) begin
                data = wresult;
            end
`endif
        end
        return data;
    endfunction

    always_comb begin
        wb.Drd1 = read_port(wb.Dra1);
        wb.Drd2 = read_port(wb.Dra2);
    end

    assign wb.Wresult   = wresult;
    assign wb.wb_count  = wb_count_q;
    assign wb.last_wadd = last_wadd_q;

endmodule
